// File: rtl/call_sequencer.sv
// call_sequencer: hands one argument tuple at a time to an external compute
// core, waits (bounded) for its completion strobe and queues the returned
// results in a small FIFO for a downstream consumer.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. in_ready depends only on registered state and
// rst, never on in_valid; out_valid depends only on registered FIFO state,
// never on out_ready. The core side is a start pulse (r_enable) answered by a
// single-cycle completion strobe (w_enable) carrying the result.
module call_sequencer #(
  parameter int TIMEOUT    = 1024,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_a,
  input  logic [9:0]  in_b,
  input  logic [9:0]  in_c,
  input  logic [9:0]  in_d,
  input  logic [12:0] in_e,
  input  logic [9:0]  in_f,
  input  logic [12:0] in_g,
  output logic        r_enable,
  output logic        controlArr,
  output logic [9:0]  init_a,
  output logic [9:0]  init_b,
  output logic [9:0]  init_c,
  output logic [9:0]  init_d,
  output logic [12:0] init_e,
  output logic [9:0]  init_f,
  output logic [12:0] init_g,
  input  logic        w_enable,
  input  logic [12:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] out_result,
  output logic        err_timeout,
  output logic [1:0]  dbg_state
);

  // The counter only has to reach TIMEOUT-1 (last WAIT cycle).
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  wait_cnt_q;
  logic           r_enable_q;
  logic           err_q;
  logic [9:0]     init_a_q, init_b_q, init_c_q, init_d_q, init_f_q;
  logic [12:0]    init_e_q, init_g_q;

  // Two-entry result FIFO: storage, pointers and occupancy.
  logic [12:0]    mem_q [2];
  logic           wr_ptr_q;
  logic           rd_ptr_q;
  logic [1:0]     count_q;

  logic           push;
  logic           pop;

  // A completion strobe only counts while a call is actually waiting.
  assign push = (state_q == S_WAIT) && w_enable && (count_q < 2'(FIFO_DEPTH));
  assign pop  = out_valid && out_ready;

  assign in_ready    = !rst && (state_q == S_IDLE) && (count_q < 2'(FIFO_DEPTH));
  assign out_valid   = (count_q != 2'd0);
  assign out_result  = out_valid ? mem_q[rd_ptr_q] : 13'd0;
  assign r_enable    = r_enable_q;
  assign controlArr  = 1'b0;
  assign err_timeout = err_q;
  assign dbg_state   = state_q;
  assign init_a      = init_a_q;
  assign init_b      = init_b_q;
  assign init_c      = init_c_q;
  assign init_d      = init_d_q;
  assign init_e      = init_e_q;
  assign init_f      = init_f_q;
  assign init_g      = init_g_q;

  // Call FSM: accept -> one-cycle start pulse -> bounded wait for the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      r_enable_q <= 1'b0;
      err_q      <= 1'b0;
      init_a_q   <= '0;
      init_b_q   <= '0;
      init_c_q   <= '0;
      init_d_q   <= '0;
      init_e_q   <= '0;
      init_f_q   <= '0;
      init_g_q   <= '0;
    end else begin
      r_enable_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            init_a_q   <= in_a;
            init_b_q   <= in_b;
            init_c_q   <= in_c;
            init_d_q   <= in_d;
            init_e_q   <= in_e;
            init_f_q   <= in_f;
            init_g_q   <= in_g;
            r_enable_q <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (w_enable) begin
            state_q <= S_IDLE;
          end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Result FIFO: simultaneous push and pop keeps the count and the order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= result;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: doc/call_sequencer.md
CALL_SEQUENCER -- requirements
Module: call_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, meaning the maximum WAIT cycles before a call is abandoned.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2 (fixed), meaning the result buffer entries.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  an argument tuple is offered.
REQ-006 in_ready  output  1  the sequencer accepts the tuple this cycle.
REQ-007 in_a, in_b, in_c, in_d, in_f  input  10 each  call arguments.
REQ-008 in_e, in_g  input  13 each  call arguments.
REQ-009 r_enable  output  1  single-cycle start pulse to the compute core.
REQ-010 controlArr  output  1  array-control line to the core, constant 0.
REQ-011 init_a..init_g  output  widths as in_a..in_g  registered arguments to the core.
REQ-012 w_enable  input  1  core completion strobe.
REQ-013 result  input  13  core result, valid while w_enable is high.
REQ-014 out_valid  output  1  FIFO head is valid.
REQ-015 out_ready  input  1  consumer takes the head.
REQ-016 out_result  output  13  FIFO head data.
REQ-017 err_timeout  output  1  sticky flag: at least one call timed out.

Function
REQ-018 SHALL implement FSM states IDLE, START, WAIT.
REQ-019 in_ready SHALL equal (state==IDLE) and (fifo_count<FIFO_DEPTH).
- Consequence: a completing call always has FIFO space.
REQ-020 On in_valid&&in_ready in IDLE, SHALL register all seven arguments into init_* and go to START.
REQ-021 In START, SHALL drive r_enable=1 for exactly that cycle, then go to WAIT; r_enable SHALL be 0 in every other state.
REQ-022 init_* SHALL hold stable from START until the FSM returns to IDLE; they change only on acceptance.
REQ-023 In WAIT, the first cycle with w_enable=1 SHALL push result into the FIFO and go to IDLE.
REQ-024 w_enable seen in IDLE or START SHALL be ignored; no push occurs.
REQ-025 Latency: accept at cycle T -> r_enable at T+1 -> w_enable sampled at T+1+k (k>=1) -> out_valid at T+2+k when the FIFO was empty.
REQ-026 A WAIT-cycle counter SHALL reset on entry to WAIT.
- If it reaches TIMEOUT without w_enable: go to IDLE, set err_timeout, push nothing.
REQ-027 FIFO SHALL be 2-entry, first in first out; pop on out_valid&&out_ready.
- Push and pop in the same cycle SHALL leave the count unchanged and order preserved.
- Pop when empty SHALL have no effect.
REQ-028 out_valid SHALL equal (fifo_count!=0); out_result SHALL be the head entry, 0 when empty.
REQ-029 result SHALL be stored unmodified (13 bits); no arithmetic is performed by this block.
REQ-030 A new call SHALL NOT start while a call is in flight; back-to-back accepts are separated by at least one IDLE cycle.

Reset
REQ-031 While rst=1, asynchronously and held:
- state=IDLE, fifo_count=0, WAIT counter=0.
- r_enable=0, controlArr=0, init_*=0, out_valid=0, out_result=0, err_timeout=0.
- in_ready=1 only after rst deasserts.
REQ-032 Reset asserted mid-call (START or WAIT) SHALL abandon the call and drop all FIFO contents; a w_enable arriving after reset release in IDLE is ignored.

Verification
REQ-033 Core stub: result=(sum of args) mod 8192, k=3. Args 123,234,345,456,567,678,789 -> one r_enable pulse; out_valid with out_result=3192 exactly 5 cycles after accept.
REQ-034 out_ready=0; three calls offered with sums 10, 20, 30 -> first two complete; in_ready stays 0 with FIFO full; third is accepted only after one pop; results pop in order 10, 20, 30.
REQ-035 Stub never raises w_enable, TIMEOUT=8 -> return to IDLE 8 WAIT cycles after START; err_timeout=1; no push; next call completes normally with err_timeout still 1.
REQ-036 rst pulsed during WAIT with one entry in the FIFO -> out_valid=0 immediately; later stray w_enable causes no push; err_timeout=0.
REQ-037 w_enable pulsed while IDLE, and simultaneous push with pop when count=1 -> no spurious entry; count stays 1 and the newer result is at the head after the pop.
